// File: rtl/mux_sched8.sv
// rtl/mux_sched8.sv - round-robin 8:1 nibble scheduler with a per-grant beat limit
// Optional build macro MUX_SCHED_PRIO_EN gives requester 0 absolute priority at arbitration.
module mux_sched8 #(
  parameter int HOLD_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  req,
  input  logic [31:0] din,
  input  logic        out_ready,
  output logic [2:0]  sel,
  output logic [7:0]  gnt,
  output logic        out_valid,
  output logic [3:0]  dout,
  output logic        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(HOLD_MAX - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] ptr;
  logic [2:0] ptr_nxt;
  logic [2:0] sel_nxt;
  logic [2:0] winner;
  logic [3:0] count;
  logic [3:0] count_nxt;
  logic       any_req;
  logic       req_sel;
  logic       xfer;

  assign any_req = |req;
  assign req_sel = req[sel];
  assign dout    = din[{sel, 2'b00} +: 4];

  // Walk ptr+7 down to ptr so the nearest requester at or after ptr is written last.
  always_comb begin
    winner = ptr;
    for (int i = 7; i >= 0; i--) begin
      if (req[3'(ptr + 3'(i))]) begin
        winner = 3'(ptr + 3'(i));
      end
    end
`ifdef MUX_SCHED_PRIO_EN
    if (req[0]) begin
      winner = 3'd0;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    count_nxt = count;
    gnt       = 8'h00;
    busy      = 1'b0;
    out_valid = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          count_nxt = 4'd0;
        end
      end
      GRANT: begin
        gnt       = 8'h01 << sel;
        busy      = 1'b1;
        out_valid = req_sel;
        xfer      = req_sel && out_ready;
        if (xfer) begin
          count_nxt = count + 4'd1;
        end
        // A dropped request ends the grant without a beat; otherwise end on the last allowed beat.
        if (!req_sel || (xfer && (count == LAST_BEAT))) begin
          state_nxt = IDLE;
          ptr_nxt   = sel + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 3'd0;
      ptr   <= 3'd0;
      count <= 4'd0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_mux_sched8.sv
// tb/tb_mux_sched8.sv - table-driven bench for mux_sched8 with hand sequences for multi-cycle cases
module tb_mux_sched8;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       busy;
    logic [3:0] dout;
  } vec_t;

  localparam logic [31:0] DIN = 32'h7E5C_A6B1;

`ifdef MUX_SCHED_PRIO_EN
  localparam logic [7:0] B_GNT  = 8'h01;
  localparam logic [2:0] B_SEL  = 3'd0;
  localparam logic [3:0] B_DOUT = 4'h1;
  localparam logic [7:0] E_GNT  = 8'h01;
  localparam logic [2:0] E_SEL  = 3'd0;
  localparam logic [3:0] E_DOUT = 4'h1;
`else
  localparam logic [7:0] B_GNT  = 8'h80;
  localparam logic [2:0] B_SEL  = 3'd7;
  localparam logic [3:0] B_DOUT = 4'h7;
  localparam logic [7:0] E_GNT  = 8'h02;
  localparam logic [2:0] E_SEL  = 3'd1;
  localparam logic [3:0] E_DOUT = 4'hB;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req;
  logic [31:0] din;
  logic        out_ready;
  logic [2:0]  sel;
  logic [7:0]  gnt;
  logic        out_valid;
  logic [3:0]  dout;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  mux_sched8 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .out_valid (out_valid),
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(logic r, logic [7:0] q, logic rd, logic [7:0] g,
                             logic [2:0] s, logic vl, logic b, logic [3:0] d);
    vec_t t;
    t.rst_n = r; t.req = q; t.rdy = rd; t.gnt = g;
    t.sel = s; t.valid = vl; t.busy = b; t.dout = d;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int   xfers;
    bit   seen;
    bit   done;

    // reset, then idle with no requests
    for (int i = 0; i < 5; i++) tbl.push_back(v(1, 8'h00, 1, 8'h00, 0, 0, 0, 4'h1));
    // req 0x81: grant 0, one idle, grant 7 (or 0 with priority), one idle, grant 0
    tbl.push_back(v(1, 8'h81, 1, 8'h00, 0, 0, 0, 4'h1));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1, 8'h81, 1, 8'h01, 0, 1, 1, 4'h1));
    tbl.push_back(v(1, 8'h81, 1, 8'h00, 0, 0, 0, 4'h1));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1, 8'h81, 1, B_GNT, B_SEL, 1, 1, B_DOUT));
    tbl.push_back(v(1, 8'h81, 1, 8'h00, B_SEL, 0, 0, B_DOUT));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1, 8'h81, 1, 8'h01, 0, 1, 1, 4'h1));
    // grant 3 with ready pattern 1,0,0,1,1,1
    tbl.push_back(v(1, 8'h08, 1, 8'h00, 0, 0, 0, 4'h1));
    tbl.push_back(v(1, 8'h08, 1, 8'h08, 3, 1, 1, 4'hA));
    tbl.push_back(v(1, 8'h08, 0, 8'h08, 3, 1, 1, 4'hA));
    tbl.push_back(v(1, 8'h08, 0, 8'h08, 3, 1, 1, 4'hA));
    for (int i = 0; i < 3; i++) tbl.push_back(v(1, 8'h08, 1, 8'h08, 3, 1, 1, 4'hA));
    // grant 5 dropped after two beats, then 6 wins
    tbl.push_back(v(1, 8'h20, 1, 8'h00, 3, 0, 0, 4'hA));
    tbl.push_back(v(1, 8'h20, 1, 8'h20, 5, 1, 1, 4'h5));
    tbl.push_back(v(1, 8'h20, 1, 8'h20, 5, 1, 1, 4'h5));
    tbl.push_back(v(1, 8'h00, 1, 8'h20, 5, 0, 1, 4'h5));
    tbl.push_back(v(1, 8'h60, 1, 8'h00, 5, 0, 0, 4'h5));
    // grant 6 while other requesters churn
    tbl.push_back(v(1, 8'h60, 0, 8'h40, 6, 1, 1, 4'hE));
    tbl.push_back(v(1, 8'h4F, 1, 8'h40, 6, 1, 1, 4'hE));
    tbl.push_back(v(1, 8'hC1, 1, 8'h40, 6, 1, 1, 4'hE));
    tbl.push_back(v(1, 8'h40, 1, 8'h40, 6, 1, 1, 4'hE));
    tbl.push_back(v(1, 8'h44, 1, 8'h40, 6, 1, 1, 4'hE));
    tbl.push_back(v(1, 8'h04, 1, 8'h00, 6, 0, 0, 4'hE));
    // grant 2, async reset mid-grant, restart from index 0
    tbl.push_back(v(1, 8'h04, 1, 8'h04, 2, 1, 1, 4'h6));
    tbl.push_back(v(0, 8'h05, 1, 8'h00, 0, 0, 0, 4'h1));
    tbl.push_back(v(1, 8'h05, 1, 8'h00, 0, 0, 0, 4'h1));
    tbl.push_back(v(1, 8'h05, 1, 8'h01, 0, 1, 1, 4'h1));
    tbl.push_back(v(1, 8'h04, 1, 8'h01, 0, 0, 1, 4'h1));
    // req 0x03 from ptr 1: alternate 1,0,1 or always 0 with priority
    tbl.push_back(v(1, 8'h03, 1, 8'h00, 0, 0, 0, 4'h1));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1, 8'h03, 1, E_GNT, E_SEL, 1, 1, E_DOUT));
    tbl.push_back(v(1, 8'h03, 1, 8'h00, E_SEL, 0, 0, E_DOUT));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1, 8'h03, 1, 8'h01, 0, 1, 1, 4'h1));
    tbl.push_back(v(1, 8'h03, 1, 8'h00, 0, 0, 0, 4'h1));
    tbl.push_back(v(1, 8'h03, 1, E_GNT, E_SEL, 1, 1, E_DOUT));

    rst_n = 1'b0;
    req = 8'h00;
    din = DIN;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      rst_n = tbl[r].rst_n;
      req = tbl[r].req;
      out_ready = tbl[r].rdy;
      #1;
      chk("gnt", r, 32'(gnt), 32'(tbl[r].gnt));
      chk("sel", r, 32'(sel), 32'(tbl[r].sel));
      chk("out_valid", r, 32'(out_valid), 32'(tbl[r].valid));
      chk("busy", r, 32'(busy), 32'(tbl[r].busy));
      chk("dout", r, 32'(dout), 32'(tbl[r].dout));
    end

    // async reset takes effect between edges
    @(negedge clk);
    rst_n = 1'b0;
    req = 8'h00;
    #1;
    chk("seq_rst_busy", 0, 32'(busy), 32'd0);
    chk("seq_rst_gnt", 0, 32'(gnt), 32'd0);

    // grant 4 under a stalling sink: exactly four beats, one idle cycle, then regrant
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'h10;
    xfers = 0;
    seen = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      out_ready = ((k % 3) != 1);
      #1;
      if (busy) begin
        seen = 1'b1;
        chk("seq_gnt", k, 32'(gnt), 32'h10);
        if (out_valid && out_ready) xfers++;
      end else if (seen) begin
        done = 1'b1;
      end
    end
    chk("seq_grant_ended", 0, 32'(done), 32'd1);
    chk("seq_beats", 0, 32'(xfers), 32'd4);
    @(negedge clk);
    #1;
    chk("seq_regrant_busy", 0, 32'(busy), 32'd1);
    chk("seq_regrant_gnt", 0, 32'(gnt), 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_sched8.md
MUX_SCHED8 -- requirements
Module: mux_sched8

Interface
REQ-001 Parameter: HOLD_MAX, default 4, max beats transferred per grant (legal 1..15).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  8  req[i] high = requester i wants the shared 4-bit path.
REQ-005 din  input  32  requester i data on din[4i+3:4i].
REQ-006 out_ready  input  1  sink accepts a beat this cycle.
REQ-007 sel  output  3  index of current grantee, driven to the shared 8:1 nibble mux.
REQ-008 gnt  output  8  one-hot grant, all-zero when no grant.
REQ-009 out_valid  output  1  beat on dout is valid.
REQ-010 dout  output  4  selected nibble din[4*sel+3:4*sel].
REQ-011 busy  output  1  high while in GRANT state.

Function
REQ-012 FSM SHALL have two states: IDLE, GRANT.
REQ-013 IDLE -> GRANT on the next edge when |req; sel loaded with winner, count cleared.
REQ-014 Winner SHALL be the first requester with req set, searching ptr, ptr+1, ... ptr+7 modulo 8.
REQ-015 In GRANT: gnt = 1<<sel, busy = 1, out_valid = req[sel]; in IDLE: gnt = 0, busy = 0, out_valid = 0.
REQ-016 dout SHALL equal the sel nibble of din combinationally at all times (including IDLE).
REQ-017 Beat transfers when out_valid && out_ready; count (4 bits) increments by 1 per transfer only.
REQ-018 out_ready low SHALL hold count, sel and state unchanged (stall, no timeout).
REQ-019 GRANT -> IDLE on next edge when req[sel] == 0, or on a transfer with count == HOLD_MAX-1.
REQ-020 On GRANT exit, ptr <= (sel+1) mod 8 (wrap 7 -> 0); ptr unchanged otherwise.
REQ-021 Grant latency: req rise in IDLE -> gnt on the following cycle; exactly one IDLE cycle between consecutive grants.
REQ-022 req changes of non-granted requesters during GRANT SHALL NOT affect sel, count or state.
REQ-023 Requester dropping req mid-grant with count < HOLD_MAX-1: no beat that cycle, grant ends, ptr advances.
REQ-024 Simultaneous last-beat transfer and req[sel] drop: single exit, ptr advances once.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, sel=0, ptr=0, count=0, gnt=0, out_valid=0, busy=0.
REQ-026 Reset asserted mid-GRANT SHALL abort the grant with no further beats; after release arbitration restarts from ptr=0.
REQ-027 First edge after rst_n rises SHALL behave as an ordinary IDLE cycle.

Configuration
REQ-028 Macro MUX_SCHED_PRIO_EN: when defined, requester 0 SHALL win arbitration whenever req[0]=1 at IDLE, regardless of ptr; ptr update rules unchanged.
REQ-029 Without MUX_SCHED_PRIO_EN, arbitration SHALL be pure round-robin per REQ-014.

Verification
REQ-030 Reset, req=8'h00 for 5 cycles -> gnt=0, out_valid=0, busy=0, sel=0 throughout.
REQ-031 req=8'h81, ptr=0, out_ready=1, HOLD_MAX=4 -> grant 0 for 4 beats, 1 IDLE cycle, grant 7 for 4 beats, 1 IDLE cycle, then grant 0 again (wrap).
REQ-032 Grant to 3, din[15:12]=4'hA, out_ready toggled 1,0,0,1,1,1 -> dout=4'hA, exactly 4 transfers, count frozen during the two stall cycles.
REQ-033 Grant to 5, req[5] dropped after 2 beats -> grant ends next edge, ptr=6, next grant to 6 when req=8'h60.
REQ-034 rst_n pulsed low mid-grant to sel=2 -> gnt=0 asynchronously, next grant after release goes to lowest set req from index 0.
REQ-035 With MUX_SCHED_PRIO_EN defined, req=8'h03 continuous, ptr=1 -> every grant goes to requester 0; without it grants alternate 1,0,1,0.
